// File: rtl/imem_loader_pkg.sv
// Shared state encoding and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StFinish = 2'd2,
        StRun    = 2'd3
    } loader_state_e;

    localparam int unsigned MAX_WORDS_DEFAULT = 16384;

    localparam logic [3:0] WEN_ALL  = 4'b1111;
    localparam logic [3:0] WEN_NONE = 4'b0000;

endpackage

// File: rtl/imem_port_mux.sv
// Combinational SRAM-port select: loader owns the port until RUN, then the CPU does.
module imem_port_mux #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_sel_cpu,
    input  logic [ADDR_W-1:0] i_ld_address,
    input  logic [3:0]        i_ld_w_en,
    input  logic [DATA_W-1:0] i_ld_w_data,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [3:0]        i_cpu_w_en,
    input  logic [DATA_W-1:0] i_cpu_w_data,
    input  logic [DATA_W-1:0] i_sram_read_data,
    output logic [ADDR_W-1:0] o_sram_address,
    output logic [3:0]        o_sram_w_en,
    output logic [DATA_W-1:0] o_sram_w_data,
    output logic [DATA_W-1:0] o_cpu_read_data
);

    always_comb begin
        if (i_sel_cpu) begin
            o_sram_address  = i_cpu_address;
            o_sram_w_en     = i_cpu_w_en;
            o_sram_w_data   = i_cpu_w_data;
            o_cpu_read_data = i_sram_read_data;
        end else begin
            o_sram_address  = i_ld_address;
            o_sram_w_en     = i_ld_w_en;
            o_sram_w_data   = i_ld_w_data;
            o_cpu_read_data = '0;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction SRAM while holding the CPU in reset, then hands over.
// Optional running checksum of accepted words: define IMEM_LOADER_CSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_start,
    input  logic [ADDR_W-1:0] i_ld_base,
    input  logic [15:0]       i_ld_len,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_ld_busy,
    output logic              o_ld_done,
    output logic              o_ld_err,
    output logic [31:0]       o_ld_csum,
    output logic              o_cpu_rst,
    input  logic [ADDR_W-1:0] i_cpu_im_address,
    input  logic [3:0]        i_cpu_im_w_en,
    input  logic [DATA_W-1:0] i_cpu_im_w_data,
    output logic [DATA_W-1:0] o_cpu_im_read_data,
    output logic [ADDR_W-1:0] o_sram_address,
    output logic [3:0]        o_sram_w_en,
    output logic [DATA_W-1:0] o_sram_w_data,
    input  logic [DATA_W-1:0] i_sram_read_data
);

    loader_state_e     r_state, w_state_d;
    logic [ADDR_W-1:0] r_base;
    logic [15:0]       r_len, r_cnt;
    logic              r_cpu_rst, r_s_ready, r_busy, r_done, r_err;

    logic              w_can_start, w_len_bad, w_start_acc, w_start_err, w_load_go;
    logic              w_hs, w_last;
    logic              w_cpu_rst_d, w_s_ready_d, w_busy_d, w_done_d;
    logic [ADDR_W-1:0] w_ld_address;
    logic [3:0]        w_ld_w_en;

    assign w_can_start = (r_state == StIdle) || (r_state == StRun);
    assign w_len_bad   = 32'(i_ld_len) > MAX_WORDS;
    assign w_start_acc = w_can_start && i_ld_start && !w_len_bad;
    assign w_start_err = w_can_start && i_ld_start && w_len_bad;
    assign w_load_go   = w_start_acc && (i_ld_len != 16'd0);
    assign w_hs        = (r_state == StLoad) && i_s_valid && r_s_ready;
    assign w_last      = (r_cnt == r_len - 16'd1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_cpu_rst <= 1'b0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cpu_rst <= w_cpu_rst_d;
            r_s_ready <= w_s_ready_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            if (w_start_err) begin
                r_err <= 1'b1;
            end else if (w_start_acc) begin
                r_err <= 1'b0;
            end
            if (w_load_go) begin
                r_base <= i_ld_base & ~ADDR_W'(3);
                r_len  <= i_ld_len;
                r_cnt  <= '0;
            end else if (w_hs) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // A rejected length leaves the current state (IDLE or RUN) untouched.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StRun: begin
                if (w_start_acc) begin
                    w_state_d = (i_ld_len == 16'd0) ? StRun : StLoad;
                end
            end
            StLoad: begin
                if (w_hs && w_last) begin
                    w_state_d = StFinish;
                end
            end
            StFinish: w_state_d = StRun;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_ld_w_en    = w_hs ? WEN_ALL : WEN_NONE;
        w_ld_address = r_base + ADDR_W'({r_cnt, 2'b00});
        w_cpu_rst_d  = (w_state_d == StRun);
        w_s_ready_d  = (w_state_d == StLoad);
        w_busy_d     = (w_state_d == StLoad) || (w_state_d == StFinish);
        w_done_d     = w_hs && w_last;
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_csum <= '0;
        end else if (w_start_acc) begin
            r_csum <= '0;
        end else if (w_hs) begin
            r_csum <= r_csum + 32'(i_s_data);
        end
    end

    assign o_ld_csum = r_csum;
`else
    assign o_ld_csum = 32'b0;
`endif

    assign o_cpu_rst = r_cpu_rst;
    assign o_s_ready = r_s_ready;
    assign o_ld_busy = r_busy;
    assign o_ld_done = r_done;
    assign o_ld_err  = r_err;

    imem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .i_sel_cpu        (r_state == StRun),
        .i_ld_address     (w_ld_address),
        .i_ld_w_en        (w_ld_w_en),
        .i_ld_w_data      (i_s_data),
        .i_cpu_address    (i_cpu_im_address),
        .i_cpu_w_en       (i_cpu_im_w_en),
        .i_cpu_w_data     (i_cpu_im_w_data),
        .i_sram_read_data (i_sram_read_data),
        .o_sram_address   (o_sram_address),
        .o_sram_w_en      (o_sram_w_en),
        .o_sram_w_data    (o_sram_w_data),
        .o_cpu_read_data  (o_cpu_im_read_data)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a behavioural SRAM and write logger.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        ld_busy, ld_done, ld_err;
    logic [31:0] ld_csum;
    logic        cpu_rst;
    logic [15:0] cpu_im_address;
    logic [3:0]  cpu_im_w_en;
    logic [31:0] cpu_im_w_data;
    logic [31:0] cpu_im_read_data;
    logic [15:0] sram_address;
    logic [3:0]  sram_w_en;
    logic [31:0] sram_w_data;
    logic [31:0] sram_read_data;

    logic [31:0] mem [0:16383];
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] prog [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_boot_loader u_dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ld_start         (ld_start),
        .i_ld_base          (ld_base),
        .i_ld_len           (ld_len),
        .i_s_valid          (s_valid),
        .o_s_ready          (s_ready),
        .i_s_data           (s_data),
        .o_ld_busy          (ld_busy),
        .o_ld_done          (ld_done),
        .o_ld_err           (ld_err),
        .o_ld_csum          (ld_csum),
        .o_cpu_rst          (cpu_rst),
        .i_cpu_im_address   (cpu_im_address),
        .i_cpu_im_w_en      (cpu_im_w_en),
        .i_cpu_im_w_data    (cpu_im_w_data),
        .o_cpu_im_read_data (cpu_im_read_data),
        .o_sram_address     (sram_address),
        .o_sram_w_en        (sram_w_en),
        .o_sram_w_data      (sram_w_data),
        .i_sram_read_data   (sram_read_data)
    );

    assign sram_read_data = mem[sram_address[15:2]];

    always @(posedge clk) begin
        if (sram_w_en != 4'b0000) begin
            mem[sram_address[15:2]] <= sram_w_data;
            wr_addr_q.push_back(sram_address);
            wr_data_q.push_back(sram_w_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_csum(input int n);
        logic [31:0] sum = 32'd0;
`ifdef IMEM_LOADER_CSUM_EN
        for (int i = 0; i < n; i++) sum = sum + prog[i];
`else
        sum = 32'(n) & 32'd0;
`endif
        return sum;
    endfunction

    task automatic load(input logic [15:0] base, input int n, input bit gappy);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        logic [15:0] exp_addr;
        wr_addr_q.delete();
        wr_data_q.delete();
        ld_base  = base;
        ld_len   = 16'(n);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_eq("load_busy", 32'(ld_busy), 32'd1);
        check_eq("load_cpu_held", 32'(cpu_rst), 32'd0);
        while (idx < n && cyc < 100) begin
            s_valid = gappy ? (cyc % 3 == 0) : 1'b1;
            s_data  = prog[idx];
            #1;
            if (!s_valid) check_eq("idle_no_write", 32'(sram_w_en), 32'd0);
            hs = s_valid && s_ready;
            tick();
            if (hs) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        check_eq("load_timeout", 32'(idx), 32'(n));
        check_eq("done_pulse", 32'(ld_done), 32'd1);
        check_eq("finish_cpu_held", 32'(cpu_rst), 32'd0);
        check_eq("finish_no_ready", 32'(s_ready), 32'd0);
        tick();
        check_eq("done_one_cycle", 32'(ld_done), 32'd0);
        check_eq("run_cpu_release", 32'(cpu_rst), 32'd1);
        check_eq("run_not_busy", 32'(ld_busy), 32'd0);
        check_eq("csum", ld_csum, exp_csum(n));
        check_eq("write_count", 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            exp_addr = base + 16'(4 * i);
            check_eq("write_addr", 32'(wr_addr_q[i]), 32'(exp_addr));
            check_eq("write_data", wr_data_q[i], prog[i]);
        end
    endtask

    initial begin
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113;
        prog[3] = 32'h0020_81B3;
        rst = 1'b0;
        ld_start = 1'b0;
        ld_base = 16'h0;
        ld_len = 16'h0;
        s_valid = 1'b0;
        s_data = 32'h0;
        cpu_im_address = 16'h0;
        cpu_im_w_en = 4'b0000;
        cpu_im_w_data = 32'h0;

        // Reset held low three cycles.
        repeat (3) tick();
        check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_sram_w_en", 32'(sram_w_en), 32'd0);
        check_eq("rst_csum", ld_csum, 32'd0);
        check_eq("rst_done", 32'(ld_done), 32'd0);
        check_eq("rst_err", 32'(ld_err), 32'd0);
        rst = 1'b1;
        tick();

        // Zero-length start jumps straight to RUN.
        ld_len = 16'd0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_eq("len0_cpu_run", 32'(cpu_rst), 32'd1);
        check_eq("len0_not_busy", 32'(ld_busy), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("rerst_cpu_held", 32'(cpu_rst), 32'd0);

        // Oversized length is rejected and flagged; IDLE is kept.
        ld_len = 16'd20000;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check_eq("err_set", 32'(ld_err), 32'd1);
        check_eq("err_not_busy", 32'(ld_busy), 32'd0);
        check_eq("err_no_ready", 32'(s_ready), 32'd0);
        tick();
        check_eq("err_sticky", 32'(ld_err), 32'd1);
        check_eq("err_cpu_held", 32'(cpu_rst), 32'd0);
        load(16'h0100, 1, 1'b0);
        check_eq("err_cleared", 32'(ld_err), 32'd0);

        load(16'h0000, 4, 1'b0);
        load(16'h0000, 4, 1'b1);
        load(16'hFFF8, 4, 1'b0);

        // CPU owns the SRAM port in RUN.
        cpu_im_address = 16'h0008;
        #1;
        check_eq("run_fetch", cpu_im_read_data, 32'h0020_0113);
        check_eq("run_fetch_wrap", mem[0], 32'h0020_0113);
        cpu_im_address = 16'h0040;
        cpu_im_w_en = 4'b1111;
        cpu_im_w_data = 32'hDEAD_BEEF;
        #1;
        check_eq("run_cpu_wen", 32'(sram_w_en), 32'hF);
        check_eq("run_cpu_wdata", sram_w_data, 32'hDEAD_BEEF);
        cpu_im_w_en = 4'b0000;

        // Reload from RUN re-asserts CPU reset; then reset mid-load.
        ld_base = 16'h0200;
        ld_len = 16'd2;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        cpu_im_w_en = 4'b1111;
        #1;
        check_eq("reload_cpu_held", 32'(cpu_rst), 32'd0);
        check_eq("reload_ready", 32'(s_ready), 32'd1);
        check_eq("reload_no_cpu_read", cpu_im_read_data, 32'd0);
        check_eq("reload_cpu_wen_ignored", 32'(sram_w_en), 32'd0);
        cpu_im_w_en = 4'b0000;
        s_valid = 1'b1;
        s_data = prog[1];
        tick();
        s_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("midrst_cpu_held", 32'(cpu_rst), 32'd0);
        check_eq("midrst_no_ready", 32'(s_ready), 32'd0);
        check_eq("midrst_not_busy", 32'(ld_busy), 32'd0);
        check_eq("midrst_csum", ld_csum, 32'd0);
        tick();
        check_eq("midrst_idle", 32'(s_ready), 32'd0);
        check_eq("midrst_idle_cpu", 32'(cpu_rst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
